// File: rtl/mips_pkg.sv
// Shared mips32 definitions: nop encoding, fetch FSM states, default reset PC.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    // Low two bits of a branch/jump target are don't-care; force word alignment.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: reset > hold > flush (bubble) > load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    logic [31:0] instr_reg;
    logic [31:0] pc4_reg;
    logic        valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_reg <= NOP;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (!hold) begin
            if (flush) begin
                instr_reg <= NOP;
                pc4_reg   <= '0;
                valid_reg <= 1'b0;
            end else if (load) begin
                instr_reg <= instr;
                pc4_reg   <= pc4;
                valid_reg <= 1'b1;
            end
        end
    end

    assign if_id_instr = instr_reg;
    assign if_id_pc4   = pc4_reg;
    assign if_id_valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// mips32 instruction-fetch stage: PC, imem request handshake, branch redirect
// with wrong-path squash, and IF/ID register control.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        isBranch,
    input  logic [31:0] target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  saved_reg;
    logic         req_reg;

    logic [31:0]  target_aligned;
    logic [31:0]  pc_plus4;
    logic         ifid_hold;
    logic         ifid_flush;
    logic         ifid_load;

    assign target_aligned = word_align(target);
    assign pc_plus4       = pc_reg + 32'd4;

    // The address bus is purely the PC register, so it cannot move mid-request.
    assign imem_addr = pc_reg;
    assign imem_req  = req_reg;

    always_comb begin
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        if (req_reg) begin
            if (state_reg == DRAIN) begin
                ifid_hold  = stall;
                ifid_flush = !stall;
            end else if (!stall) begin
                ifid_hold = 1'b0;
                if (!isBranch && imem_ready) begin
                    ifid_load = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            saved_reg <= '0;
            req_reg   <= 1'b0;
        end else begin
            req_reg <= 1'b1;
            // Nothing is outstanding in the first cycle after reset, so responses are ignored.
            if (req_reg) begin
                case (state_reg)
                    FETCH, WAIT_MEM: begin
                        if (!stall) begin
                            if (isBranch) begin
                                if (imem_ready) begin
                                    pc_reg    <= target_aligned;
                                    state_reg <= FETCH;
                                end else begin
                                    saved_reg <= target_aligned;
                                    state_reg <= DRAIN;
                                end
                            end else if (imem_ready) begin
                                pc_reg    <= pc_plus4;
                                state_reg <= FETCH;
                            end else begin
                                state_reg <= WAIT_MEM;
                            end
                        end
                    end
                    DRAIN: begin
                        // A newer branch decision replaces the saved target, even on the drain cycle.
                        if (isBranch && !stall) begin
                            saved_reg <= target_aligned;
                        end
                        if (imem_ready) begin
                            pc_reg    <= (isBranch && !stall) ? target_aligned : saved_reg;
                            state_reg <= FETCH;
                        end
                    end
                    default: state_reg <= FETCH;
                endcase
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clock       (clock),
        .reset       (reset),
        .hold        (ifid_hold),
        .flush       (ifid_flush),
        .load        (ifid_load),
        .instr       (imem_data),
        .pc4         (pc_plus4),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the corner cases, then
// randomized traffic checked against a behavioural fetch model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        isBranch;
    logic [31:0] target;
    logic        stall;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .isBranch    (isBranch),
        .target      (target),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Address-tagged instruction memory; junk on the bus when not ready.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0003;
    endfunction

    assign imem_data = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic        rdy;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc4;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                                input logic rdy, input logic [31:0] tgt,
                                input logic [31:0] e_addr, input logic e_req,
                                input logic e_valid, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.rdy = rdy; v.tgt = tgt;
        v.e_addr = e_addr; v.e_req = e_req; v.e_valid = e_valid; v.e_pc4 = e_pc4;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic stl, input logic br,
                         input logic rdy, input logic [31:0] tgt);
        @(negedge clock);
        reset      = rst;
        stall      = stl;
        isBranch   = br;
        imem_ready = rdy;
        target     = tgt;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] e_addr, input logic e_req,
                         input logic e_valid, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4);
        n_vec++;
        if (imem_addr !== e_addr || imem_req !== e_req || if_id_valid !== e_valid ||
            if_id_instr !== e_instr || (e_valid && if_id_pc4 !== e_pc4)) begin
            n_err++;
            $display("FAIL %s: addr=%h want %h req=%b want %b valid=%b want %b instr=%h want %h pc4=%h want %h",
                     name, imem_addr, e_addr, imem_req, e_req, if_id_valid, e_valid,
                     if_id_instr, e_instr, if_id_pc4, e_pc4);
        end else begin
            $display("vec %0d %s: addr=%h req=%b valid=%b instr=%h pc4=%h",
                     n_vec, name, imem_addr, imem_req, if_id_valid, if_id_instr, if_id_pc4);
        end
    endtask

    // Behavioural model: where the PC goes, and what IF/ID holds, after each edge.
    logic [31:0] m_pc, m_pending, m_instr, m_pc4;
    logic        m_req, m_valid, m_squash;

    task automatic model_step(input logic rst, input logic stl, input logic br,
                              input logic rdy, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_req = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
            m_pc4 = 32'h0; m_squash = 1'b0; m_pending = 32'h0;
        end else if (!m_req) begin
            m_req = 1'b1;
        end else if (m_squash) begin
            // a wrong-path response is still outstanding
            if (!stl && br) m_pending = t;
            if (rdy) begin m_pc = m_pending; m_squash = 1'b0; end
            if (!stl) begin m_valid = 1'b0; m_instr = 32'h0; end
        end else if (stl) begin
            // everything holds
        end else if (br) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (rdy) m_pc = t;
            else begin m_pending = t; m_squash = 1'b1; end
        end else if (rdy) begin
            m_instr = word_at(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
    endtask

    vec_t tbl[31];

    initial begin
        logic [31:0] e_instr;
        logic [31:0] pc_before;
        reset = 1'b1; stall = 1'b0; isBranch = 1'b0; imem_ready = 1'b0; target = 32'h0;

        //             rst stl br rdy target        addr          req valid pc4
        tbl[0]  = mk(1, 0, 0, 1, 32'h0,         32'h0,         0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 1, 32'h0,         32'h4,         1, 1, 32'h4);
        tbl[3]  = mk(0, 0, 0, 1, 32'h0,         32'h8,         1, 1, 32'h8);
        tbl[4]  = mk(0, 0, 1, 1, 32'h40,        32'h40,        1, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 1, 32'h0,         32'h44,        1, 1, 32'h44);
        tbl[6]  = mk(0, 0, 1, 1, 32'h43,        32'h40,        1, 0, 32'h0);
        tbl[7]  = mk(0, 0, 0, 1, 32'h0,         32'h44,        1, 1, 32'h44);
        tbl[8]  = mk(0, 1, 1, 1, 32'h100,       32'h44,        1, 1, 32'h44);
        tbl[9]  = mk(0, 1, 1, 1, 32'h100,       32'h44,        1, 1, 32'h44);
        tbl[10] = mk(0, 0, 1, 1, 32'h100,       32'h100,       1, 0, 32'h0);
        tbl[11] = mk(0, 0, 0, 1, 32'h0,         32'h104,       1, 1, 32'h104);
        tbl[12] = mk(0, 0, 1, 1, 32'h10,        32'h10,        1, 0, 32'h0);
        tbl[13] = mk(0, 0, 1, 0, 32'h80,        32'h10,        1, 0, 32'h0);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,         32'h10,        1, 0, 32'h0);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,         32'h10,        1, 0, 32'h0);
        tbl[16] = mk(0, 0, 0, 1, 32'h0,         32'h80,        1, 0, 32'h0);
        tbl[17] = mk(0, 0, 0, 1, 32'h0,         32'h84,        1, 1, 32'h84);
        tbl[18] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'h0);
        tbl[19] = mk(0, 0, 0, 1, 32'h0,         32'h0,         1, 1, 32'h0);
        tbl[20] = mk(0, 0, 0, 1, 32'h0,         32'h4,         1, 1, 32'h4);
        tbl[21] = mk(0, 0, 1, 0, 32'h200,       32'h4,         1, 0, 32'h0);
        tbl[22] = mk(1, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0);
        tbl[23] = mk(0, 0, 0, 1, 32'h0,         32'h0,         1, 0, 32'h0);
        tbl[24] = mk(0, 0, 0, 1, 32'h0,         32'h4,         1, 1, 32'h4);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,         32'h4,         1, 0, 32'h0);
        tbl[26] = mk(0, 0, 0, 1, 32'h0,         32'h8,         1, 1, 32'h8);
        tbl[27] = mk(0, 0, 1, 0, 32'h300,       32'h8,         1, 0, 32'h0);
        tbl[28] = mk(0, 0, 1, 0, 32'h400,       32'h8,         1, 0, 32'h0);
        tbl[29] = mk(0, 0, 0, 1, 32'h0,         32'h400,       1, 0, 32'h0);
        tbl[30] = mk(0, 0, 0, 1, 32'h0,         32'h404,       1, 1, 32'h404);

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].br, tbl[i].rdy, tbl[i].tgt);
            pc_before = tbl[i].e_pc4 - 32'd4;
            e_instr   = tbl[i].e_valid ? word_at(pc_before) : 32'h0;
            check($sformatf("table%0d", i), tbl[i].e_addr, tbl[i].e_req,
                  tbl[i].e_valid, e_instr, tbl[i].e_pc4);
        end

        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_stl, r_br, r_rdy;
            logic [31:0] r_tgt;
            r_rst = (i == 0) || ($urandom_range(0, 59) == 0);
            r_stl = ($urandom_range(0, 4) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFFC;
            drive(r_rst, r_stl, r_br, r_rdy, r_tgt);
            model_step(r_rst, r_stl, r_br, r_rdy, r_tgt);
            check($sformatf("rand%0d", i), m_pc, m_req, m_valid, m_instr, m_pc4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
